// File: rtl/plane_hit_manager.sv
// Per-frame collision and life manager for the player plane: hit detection, lives,
// invincibility window and game over. Optional blink during invincibility: PLANE_HIT_BLINK_EN.
module plane_hit_manager #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned INV_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic       plane_en,
    input  logic       enemy_en,
    input  logic       ebullet_en,
    input  logic       restart,
    output logic       boom,
    output logic [2:0] lives,
    output logic       invincible,
    output logic       game_over,
    output logic       plane_visible,
    output logic [7:0] hit_count
);

    typedef enum logic [1:0] {
        ALIVE,
        INVINCIBLE,
        OVER
    } state_e;

    localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);
    localparam logic [7:0] INV_LOAD  = 8'(INV_FRAMES);

    state_e     state_q, state_d;
    logic [7:0] inv_cnt_q, inv_cnt_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic       hit_seen_q, hit_seen_d;
    logic       boom_q, boom_d;
    logic       invincible_q, invincible_d;
    logic       game_over_q, game_over_d;

    logic ov;
    logic frame_hit;

    assign ov        = pix_valid & plane_en & (enemy_en | ebullet_en);
    // A hit on the boundary pixel belongs to the frame that is closing.
    assign frame_hit = hit_seen_q | ov;

    always_comb begin
        hit_seen_d = hit_seen_q;
        if (restart || frame_start) begin
            hit_seen_d = 1'b0;
        end else if (ov) begin
            hit_seen_d = 1'b1;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        inv_cnt_d   = inv_cnt_q;
        lives_d     = lives_q;
        hit_count_d = hit_count_q;
        boom_d      = 1'b0;
        if (restart) begin
            state_d     = ALIVE;
            inv_cnt_d   = 8'd0;
            lives_d     = LIVES_RST;
            hit_count_d = 8'd0;
        end else if (frame_start) begin
            unique case (state_q)
                ALIVE: begin
                    if (frame_hit && lives_q != 3'd0) begin
                        boom_d      = 1'b1;
                        lives_d     = lives_q - 3'd1;
                        hit_count_d = (hit_count_q == 8'hFF) ? hit_count_q : hit_count_q + 8'd1;
                        if (lives_q == 3'd1) begin
                            state_d = OVER;
                        end else begin
                            state_d   = INVINCIBLE;
                            inv_cnt_d = INV_LOAD;
                        end
                    end
                end
                INVINCIBLE: begin
                    inv_cnt_d = inv_cnt_q - 8'd1;
                    if (inv_cnt_q <= 8'd1) begin
                        inv_cnt_d = 8'd0;
                        state_d   = ALIVE;
                    end
                end
                OVER: begin
                    lives_d = 3'd0;
                end
                default: state_d = ALIVE;
            endcase
        end
    end

    always_comb begin
        invincible_d = (state_d == INVINCIBLE);
        game_over_d  = (state_d == OVER);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ALIVE;
            inv_cnt_q    <= 8'd0;
            lives_q      <= LIVES_RST;
            hit_count_q  <= 8'd0;
            hit_seen_q   <= 1'b0;
            boom_q       <= 1'b0;
            invincible_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            inv_cnt_q    <= inv_cnt_d;
            lives_q      <= lives_d;
            hit_count_q  <= hit_count_d;
            hit_seen_q   <= hit_seen_d;
            boom_q       <= boom_d;
            invincible_q <= invincible_d;
            game_over_q  <= game_over_d;
        end
    end

`ifdef PLANE_HIT_BLINK_EN
    logic [1:0] blink_q, blink_d;
    logic       plane_visible_q, plane_visible_d;

    // Counter sits at 0 outside the window, so it starts at 0 on entry.
    always_comb begin
        blink_d = blink_q;
        if (restart || state_q != INVINCIBLE) begin
            blink_d = 2'd0;
        end else if (frame_start) begin
            blink_d = blink_q + 2'd1;
        end
        plane_visible_d = (state_d == INVINCIBLE) ? blink_d[1] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q         <= 2'd0;
            plane_visible_q <= 1'b1;
        end else begin
            blink_q         <= blink_d;
            plane_visible_q <= plane_visible_d;
        end
    end

    assign plane_visible = plane_visible_q;
`else
    assign plane_visible = 1'b1;
`endif

    assign boom       = boom_q;
    assign lives      = lives_q;
    assign invincible = invincible_q;
    assign game_over  = game_over_q;
    assign hit_count  = hit_count_q;

endmodule

// File: tb/tb_plane_hit_manager.sv
// Scoreboard bench for plane_hit_manager: two instances (3 lives / 4 frames and
// 2 lives / 8 frames) share stimulus; a behavioural model predicts every cycle.
module tb_plane_hit_manager;

    typedef logic [14:0] obs_t;  // {boom, lives[2:0], invincible, game_over, plane_visible, hit_count[7:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, frame_start, pix_valid, plane_en, enemy_en, ebullet_en, restart;
    logic       a_boom, a_inv, a_go, a_vis, b_boom, b_inv, b_go, b_vis;
    logic [2:0] a_lives, b_lives;
    logic [7:0] a_hc, b_hc;

    plane_hit_manager #(.LIVES_INIT(3), .INV_FRAMES(4)) dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .plane_en(plane_en), .enemy_en(enemy_en), .ebullet_en(ebullet_en), .restart(restart),
        .boom(a_boom), .lives(a_lives), .invincible(a_inv), .game_over(a_go),
        .plane_visible(a_vis), .hit_count(a_hc)
    );

    plane_hit_manager #(.LIVES_INIT(2), .INV_FRAMES(8)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .plane_en(plane_en), .enemy_en(enemy_en), .ebullet_en(ebullet_en), .restart(restart),
        .boom(b_boom), .lives(b_lives), .invincible(b_inv), .game_over(b_go),
        .plane_visible(b_vis), .hit_count(b_hc)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model state per instance: st 0=ALIVE 1=INVINCIBLE 2=OVER
    int m_init[2] = '{3, 2};
    int m_nfr[2]  = '{4, 8};
    int m_st[2], m_lives[2], m_inv[2], m_hits[2], m_blink[2];
    bit m_seen[2], m_boom[2];

    logic [29:0] exp_q[$];
    logic [29:0] act_q[$];

    function automatic obs_t model_obs(int k);
        logic vis;
        logic [1:0] bl;
        bl  = 2'(m_blink[k]);
        vis = 1'b1;
`ifdef PLANE_HIT_BLINK_EN
        if (m_st[k] == 1) vis = bl[1];
`endif
        return {m_boom[k], 3'(m_lives[k]), m_st[k] == 1, m_st[k] == 2, vis, 8'(m_hits[k])};
    endfunction

    function automatic obs_t dut_obs(int k);
        if (k == 0) return {a_boom, a_lives, a_inv, a_go, a_vis, a_hc};
        return {b_boom, b_lives, b_inv, b_go, b_vis, b_hc};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_lives[k] = m_init[k]; m_inv[k] = 0; m_hits[k] = 0;
            m_blink[k] = 0; m_seen[k] = 0; m_boom[k] = 0;
        end
    endtask

    task automatic model_step(int k, bit ov, bit fs, bit rs);
        bit fh;
        fh = m_seen[k] | ov;
        m_boom[k] = 0;
        if (rs) begin
            m_st[k] = 0; m_lives[k] = m_init[k]; m_inv[k] = 0; m_hits[k] = 0;
            m_seen[k] = 0; m_blink[k] = 0;
        end else if (fs) begin
            m_seen[k] = 0;
            if (m_st[k] == 0 && fh) begin
                m_boom[k] = 1;
                m_lives[k]--;
                if (m_hits[k] < 255) m_hits[k]++;
                if (m_lives[k] == 0) m_st[k] = 2;
                else begin m_st[k] = 1; m_inv[k] = m_nfr[k]; m_blink[k] = 0; end
            end else if (m_st[k] == 1) begin
                m_inv[k]--;
                m_blink[k] = (m_blink[k] + 1) % 4;
                if (m_inv[k] == 0) m_st[k] = 0;
            end
        end else if (ov) begin
            m_seen[k] = 1;
        end
    endtask

    // One clock cycle: drive inputs, predict, then sample after the edge.
    task automatic step(bit pv, bit pe, bit ee, bit be, bit fs, bit rs);
        bit ov;
        pix_valid = pv; plane_en = pe; enemy_en = ee; ebullet_en = be;
        frame_start = fs; restart = rs;
        ov = pv & pe & (ee | be);
        model_step(0, ov, fs, rs);
        model_step(1, ov, fs, rs);
        exp_q.push_back({model_obs(0), model_obs(1)});
        @(posedge clk);
        @(negedge clk);
        act_q.push_back({dut_obs(0), dut_obs(1)});
    endtask

    // kind: 0 no hit, 1 enemy hit, 2 bullet hit; includes ignored non-overlaps.
    task automatic frame(int kind);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, kind == 1, kind == 2, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        logic [29:0] want;
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        exp_q.delete(); act_q.delete();
        model_reset();
        want = {1'b0, 3'd3, 3'b001, 8'd0, 1'b0, 3'd2, 3'b001, 8'd0};
        compared++;
        if ({dut_obs(0), dut_obs(1)} !== want) begin
            mismatched++;
            $display("FAIL reset_values: got %h want %h", {dut_obs(0), dut_obs(1)}, want);
        end
        rst = 1'b0;
        step(1, 1, 1, 0, 0, 0);
        rst = 1'b1;  // mid-frame: accumulated hit must be lost
        #1;
        model_reset();
        compared++;
        if ({dut_obs(0), dut_obs(1)} !== want) begin
            mismatched++;
            $display("FAIL async_reset: got %h want %h", {dut_obs(0), dut_obs(1)}, want);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 1, 0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL reset_seq: got %h want %h", o, e); end
        end
    endtask

    task automatic test_single_hit();
        frame(1);
        compared++;
        if ({a_boom, a_lives, a_inv, a_hc} !== {1'b1, 3'd2, 1'b1, 8'd1}) begin
            mismatched++;
            $display("FAIL single_hit_a: got %h want %h", {a_boom, a_lives, a_inv, a_hc}, {1'b1, 3'd2, 1'b1, 8'd1});
        end
        step(0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL single_hit: got %h want %h", o, e); end
        end
    endtask

    task automatic test_inv_window();
        for (int i = 0; i < 4; i++) frame(2);
        compared++;
        if ({a_inv, a_lives} !== {1'b0, 3'd2}) begin
            mismatched++;
            $display("FAIL inv_window_end: got %h want %h", {a_inv, a_lives}, {1'b0, 3'd2});
        end
        frame(1);
        compared++;
        if ({a_boom, a_lives} !== {1'b1, 3'd1}) begin
            mismatched++;
            $display("FAIL inv_next_hit: got %h want %h", {a_boom, a_lives}, {1'b1, 3'd1});
        end
        for (int i = 0; i < 4; i++) frame(0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL inv_window: got %h want %h", o, e); end
        end
    endtask

    task automatic test_gating_boundary();
        frame(0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 0);  // overlap on the frame_start cycle itself
        compared++;
        if ({a_boom, a_lives, a_go} !== {1'b1, 3'd0, 1'b1}) begin
            mismatched++;
            $display("FAIL boundary_fatal: got %h want %h", {a_boom, a_lives, a_go}, {1'b1, 3'd0, 1'b1});
        end
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL gating_boundary: got %h want %h", o, e); end
        end
    endtask

    task automatic test_fatal_hold();
        frame(1);
        frame(2);
        step(1, 1, 1, 1, 1, 0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL fatal_hold: got %h want %h", o, e); end
        end
    endtask

    task automatic test_restart();
        step(0, 0, 0, 0, 0, 1);
        compared++;
        if ({a_lives, a_go, a_hc} !== {3'd3, 1'b0, 8'd0}) begin
            mismatched++;
            $display("FAIL restart_over: got %h want %h", {a_lives, a_go, a_hc}, {3'd3, 1'b0, 8'd0});
        end
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 1, 1);  // restart wins over frame_start with a hit
        step(1, 0, 0, 0, 1, 0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL restart: got %h want %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL back_to_back: got %h want %h", o, e); end
        end
    endtask

    task automatic test_blink();
        logic [8:0] pattern;
        logic       want;
        pattern = 9'b1_1100_1100;  // bit i: visibility i frames into the window
        step(0, 0, 0, 0, 0, 1);
        frame(1);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) frame(0);
`ifdef PLANE_HIT_BLINK_EN
            want = pattern[i];
`else
            want = 1'b1;
`endif
            compared++;
            if (b_vis !== want) begin
                mismatched++;
                $display("FAIL blink_frame%0d: got %b want %b", i, b_vis, want);
            end
        end
        while (exp_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_q.pop_front(); o = act_q.pop_front(); compared++;
            if (o !== e) begin mismatched++; $display("FAIL blink: got %h want %h", o, e); end
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; plane_en = 1'b0;
        enemy_en = 1'b0; ebullet_en = 1'b0; restart = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_inv_window();
        test_gating_boundary();
        test_fatal_hold();
        test_restart();
        test_back_to_back();
        test_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
